// File: rtl/systolic_skew_feeder.sv
// Skewed ifmap feeder for a systolic sub-array: accepts unskewed row vectors
// and delays lane r by r+1 cycles so each row sees its element one cycle after the row above.
//
// state  | meaning
// IDLE   | waiting for start; tile_len sampled on accept
// STREAM | accepting vectors until the latched length has transferred
// DRAIN  | ROWS-1 cycles letting the final wavefront reach the last lane
// DONE   | single-cycle completion pulse
module systolic_skew_feeder #(
  parameter int ROWS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LEN    = 64,
  localparam int CNT_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [CNT_W-1:0]                    tile_len,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [ROWS-1:0][DATA_WIDTH-1:0] in_data,
  output logic signed [ROWS-1:0][DATA_WIDTH-1:0] array_ifmap_out,
  output logic [ROWS-1:0]                     lane_valid,
  output logic                                busy,
  output logic                                done
);

  localparam int DRN_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] acc_cnt;
  logic [DRN_W-1:0] drn_cnt;
  logic             xfer;
  logic             last_xfer;

  // in_ready depends only on state and count so it never loops back through in_valid
  assign in_ready  = (state == S_STREAM) && (acc_cnt < len_q);
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && ((acc_cnt + CNT_W'(1)) == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      len_q   <= '0;
      acc_cnt <= '0;
      drn_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q   <= tile_len;
            acc_cnt <= '0;
            busy    <= 1'b1;
            if (tile_len != '0) begin
              state <= S_STREAM;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (xfer) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (last_xfer) begin
              if (ROWS > 1) begin
                state   <= S_DRAIN;
                drn_cnt <= DRN_W'(ROWS - 1);
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          drn_cnt <= drn_cnt - DRN_W'(1);
          if (drn_cnt == DRN_W'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Every lane shifts every cycle; non-transfer cycles inject zero bubbles so
  // stalls stay aligned on the same wavefront across all lanes.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_WIDTH-1:0] dat_q [0:r];
    logic [r:0]            vld_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        for (int s = 0; s <= r; s++) dat_q[s] <= '0;
      end else begin
        vld_q[0] <= xfer;
        dat_q[0] <= xfer ? in_data[r] : '0;
        for (int s = 1; s <= r; s++) begin
          vld_q[s] <= vld_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end

    assign array_ifmap_out[r] = dat_q[r];
    assign lane_valid[r]      = vld_q[r];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed and randomized bench for systolic_skew_feeder: per-lane scoreboard
// plus handshake, done-timing and reset checks.
module tb_systolic_skew_feeder;
  localparam int ROWS  = 4;
  localparam int DW    = 16;
  localparam int MAXL  = 64;
  localparam int CNT_W = $clog2(MAXL + 1);

  logic                              clk = 1'b0;
  logic                              rst;
  logic                              start;
  logic [CNT_W-1:0]                  tile_len;
  logic                              in_valid;
  logic                              in_ready;
  logic signed [ROWS-1:0][DW-1:0]    in_data;
  logic signed [ROWS-1:0][DW-1:0]    array_ifmap_out;
  logic [ROWS-1:0]                   lane_valid;
  logic                              busy;
  logic                              done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;
  int last;

  logic [DW-1:0]   sb [ROWS][$];
  logic [ROWS-1:0] hist = '0;

  systolic_skew_feeder #(.ROWS(ROWS), .DATA_WIDTH(DW), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_len(tile_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .array_ifmap_out(array_ifmap_out), .lane_valid(lane_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: outputs checked first, then this cycle's transfer is recorded.
  always @(negedge clk) begin
    if (rst) begin
      hist = '0;
      for (int r = 0; r < ROWS; r++) sb[r].delete();
    end else begin
      check("lane_valid", 64'(lane_valid), 64'(hist));
      for (int r = 0; r < ROWS; r++) begin
        logic [DW-1:0] exp_d;
        exp_d = 'x;
        if (hist[r]) begin
          if (sb[r].size() > 0) exp_d = sb[r].pop_front();
          check("lane_data", 64'(array_ifmap_out[r]), 64'(exp_d));
        end else begin
          check("lane_bubble_zero", 64'(array_ifmap_out[r]), 64'd0);
        end
      end
      hist = {hist[ROWS-2:0], in_valid && in_ready};
      if (in_valid && in_ready)
        for (int r = 0; r < ROWS; r++) sb[r].push_back(in_data[r]);
    end
  end

  task automatic begin_tile(input int len);
    start    = 1'b1;
    tile_len = CNT_W'(len);
    step();
    start = 1'b0;
    t0    = cyc;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Feed n vectors starting at offset 0 (first STREAM cycle); returns offset of last transfer.
  task automatic feed(input int n, input logic [31:0] stall_mask, input int pct,
                      input bit seq, input int start_at, output int last_off);
    int got = 0;
    int k   = 0;
    last_off = 0;
    while (got < n && k < 2000) begin
      in_valid = !((k < 32) && stall_mask[k]) && ($urandom_range(99) < pct);
      for (int r = 0; r < ROWS; r++)
        in_data[r] = seq ? DW'(4 * got + r + 1) : DW'($urandom);
      if (k == start_at) begin
        start    = 1'b1;
        tile_len = CNT_W'(2);
      end else begin
        start = 1'b0;
      end
      check("in_ready_stream", 64'(in_ready), 64'd1);
      if (in_valid) begin
        got++;
        last_off = k;
      end
      k++;
      step();
    end
    in_valid = 1'b1;
    start    = 1'b0;
    check("feed_count", 64'(got), 64'(n));
    check("in_ready_drain", 64'(in_ready), 64'd0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int last_off, input int exp_l3);
    int k = 0;
    while (done !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    check("done_offset", 64'(cyc - t0), 64'(last_off + ROWS));
    check("busy_in_done", 64'(busy), 64'd1);
    if (exp_l3 >= 0) begin
      check("lane3_valid_at_done", 64'(lane_valid[ROWS-1]), 64'd1);
      check("lane3_data_at_done", 64'(array_ifmap_out[ROWS-1]), 64'(DW'(exp_l3)));
    end
    step();
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    tile_len = '0;
    in_valid = 1'b0;
    in_data  = '0;
    step();
    step();
    check("rst_lane_valid", 64'(lane_valid), 64'd0);
    check("rst_ifmap", 64'(array_ifmap_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    step();

    // Basic tile, in_valid held high
    begin_tile(3);
    feed(3, 32'h0, 100, 1'b1, -1, last);
    check("basic_last_off", 64'(last), 64'd2);
    wait_done(last, 12);
    step();

    // Single stall on the second STREAM cycle
    begin_tile(3);
    feed(3, 32'h2, 100, 1'b1, -1, last);
    wait_done(last, 12);
    step();

    // Zero-length tile
    in_valid = 1'b1;
    begin_tile(0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_in_ready", 64'(in_ready), 64'd0);
    step();
    check("zero_busy_after", 64'(busy), 64'd0);
    check("zero_done_after", 64'(done), 64'd0);
    check("zero_in_ready_after", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    step();

    // start during STREAM with a different length is ignored
    begin_tile(4);
    feed(4, 32'h4, 100, 1'b1, 1, last);
    wait_done(last, 16);
    step();

    // Reset two cycles into a 5-vector tile
    begin_tile(5);
    in_valid = 1'b1;
    in_data  = '1;
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_lane_valid", 64'(lane_valid), 64'd0);
    check("midrst_ifmap", 64'(array_ifmap_out), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_no_done", 64'(done), 64'd0);
      check("post_rst_idle", 64'(busy), 64'd0);
    end
    begin_tile(1);
    feed(1, 32'h0, 100, 1'b1, -1, last);
    wait_done(last, 4);
    step();

    // Randomized tiles and stall patterns
    for (int t = 0; t < 6; t++) begin
      begin_tile($urandom_range(MAXL, 1));
      feed(int'(tile_len), 32'h0, 70, 1'b0, -1, last);
      wait_done(last, -1);
      repeat ($urandom_range(3, 1)) step();
    end

    repeat (ROWS + 2) step();
    for (int r = 0; r < ROWS; r++) check("sb_drained", 64'(sb[r].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
